aes_core_scheduler: RTL

Shares one combinational `AES_encryption` core between two requesters. Each requester hands over a 128-bit plaintext and 128-bit key with a valid/ready handshake. The block grants the core round-robin, drives and holds the core inputs for a fixed settle time, then captures `dataout`. It returns the ciphertext tagged with the requester id through a valid/ready response port. It sits between the host-side request sources and the single encryption datapath.

---
 rtl/aes_core_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/aes_core_scheduler.sv
// -----------------------------------------------------------------------------
// aes_core_scheduler
// Shares one combinational AES_encryption core between two requesters.
// Round-robin grant in IDLE, registered drive of the core inputs for
// CORE_LATENCY cycles, then capture of the core output into a valid/ready
// response tagged with the owning requester id.
//
// Parameters
//   CORE_LATENCY : edges between core inputs registered and dataout sampled
//                  (legal range 1..15)
// Ports
//   clock, reset                 : rising-edge clock, async active-high reset
//   reqN_valid / reqN_ready      : job handshake for requester N (N = 0, 1)
//   reqN_text / reqN_key         : 128-bit plaintext and cipher key
//   core_plain_text / core_key   : registered drive to the shared core
//   core_dataout                 : ciphertext from the shared core
//   resp_valid / resp_ready      : response handshake
//   resp_data / resp_id          : ciphertext and owning requester id
//   busy                         : high whenever the FSM is not IDLE
// Build options
//   AES_SCHED_ZEROIZE_EN : clear the core inputs on the edge entering RESP
// -----------------------------------------------------------------------------
module aes_core_scheduler #(
   parameter  int unsigned CORE_LATENCY = 1,
   localparam int unsigned DATA_W       = 128
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_text,
   input  logic [DATA_W-1:0] req0_key,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_text,
   input  logic [DATA_W-1:0] req1_key,
   output logic [DATA_W-1:0] core_plain_text,
   output logic [DATA_W-1:0] core_key,
   input  logic [DATA_W-1:0] core_dataout,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_id,
   output logic              busy
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_last_grant;

   logic               w_any_valid;
   logic               w_grant;
   logic               w_idle;

   // Round-robin arbitration: a lone requester wins, contention goes to the
   // requester that was not served last.
   always_comb begin
      w_any_valid = req0_valid | req1_valid;
      w_grant     = 1'b0;
      if (req0_valid && req1_valid) begin
         w_grant = ~r_last_grant;
      end else if (req1_valid) begin
         w_grant = 1'b1;
      end
   end

   // Readies are held low while reset is asserted so nothing is offered
   // before the first post-reset edge.
   assign w_idle     = (r_state == ST_IDLE) && !reset;
   assign req0_ready = w_idle && req0_valid && !w_grant;
   assign req1_ready = w_idle && req1_valid &&  w_grant;

   // Scheduler FSM with registered core drive and response outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_cnt           <= '0;
         r_last_grant    <= 1'b1;
         core_plain_text <= '0;
         core_key        <= '0;
         resp_valid      <= 1'b0;
         resp_data       <= '0;
         resp_id         <= 1'b0;
         busy            <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_valid) begin
                  core_plain_text <= w_grant ? req1_text : req0_text;
                  core_key        <= w_grant ? req1_key  : req0_key;
                  resp_id         <= w_grant;
                  r_last_grant    <= w_grant;
                  r_cnt           <= CNT_W'(CORE_LATENCY);
                  r_state         <= ST_RUN;
                  busy            <= 1'b1;
               end
            end

            ST_RUN: begin
               r_cnt <= r_cnt - CNT_W'(1);
               // Last settle cycle: the core output is now valid.
               if (r_cnt == CNT_W'(1)) begin
                  resp_data  <= core_dataout;
                  resp_valid <= 1'b1;
                  r_state    <= ST_RESP;
`ifdef AES_SCHED_ZEROIZE_EN
                  core_plain_text <= '0;
                  core_key        <= '0;
`else
                  core_plain_text <= core_plain_text;
                  core_key        <= core_key;
`endif
               end
            end

            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  r_state    <= ST_IDLE;
                  busy       <= 1'b0;
               end
            end

            default: begin
               r_state    <= ST_IDLE;
               resp_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
